// File: rtl/lif_step_if.sv
// Step handshake, stimulus and result bundle for lif_neuron_array.
// The spike-counter signals exist only when LIF_SPIKE_COUNT_EN is defined.
interface lif_step_if #(
   parameter int N  = 7,
   parameter int VW = 20
);
   logic              step_valid;
   logic              step_ready;
   logic [N-1:0]      ext_spikes;
   logic [N*N*16-1:0] weights_flat;
   logic [N-1:0]      spikes;
   logic              spikes_valid;
   logic [N*VW-1:0]   membrane_flat;
`ifdef LIF_SPIKE_COUNT_EN
   logic              count_clear;
   logic [N*8-1:0]    spike_count_flat;

   modport master (
      output step_valid, ext_spikes, weights_flat, count_clear,
      input  step_ready, spikes, spikes_valid, membrane_flat, spike_count_flat
   );
   modport slave (
      input  step_valid, ext_spikes, weights_flat, count_clear,
      output step_ready, spikes, spikes_valid, membrane_flat, spike_count_flat
   );
`else
   modport master (
      output step_valid, ext_spikes, weights_flat,
      input  step_ready, spikes, spikes_valid, membrane_flat
   );
   modport slave (
      input  step_valid, ext_spikes, weights_flat,
      output step_ready, spikes, spikes_valid, membrane_flat
   );
`endif
endinterface

// File: rtl/lif_neuron_array.sv
// Array of N leaky integrate-and-fire neurons; recurrent input is applied one presynaptic
// neuron per cycle. Define LIF_SPIKE_COUNT_EN to add saturating per-neuron spike counters.
module lif_neuron_array #(
   parameter int N          = 7,
   parameter int VW         = 20,
   parameter int THRESH     = 4000,
   parameter int V_RESET    = 0,
   parameter int LEAK_SHIFT = 4,
   parameter int EXT_W      = 1000,
   parameter int REFRAC     = 2
) (
   input logic       clk,
   input logic       reset_n,
   lif_step_if.slave bus
);
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
   localparam int XW = VW + 2;

   localparam logic signed [XW-1:0] V_MAX    = XW'((2 ** (VW - 1)) - 1);
   localparam logic signed [XW-1:0] V_MIN    = XW'(-(2 ** (VW - 1)));
   localparam logic signed [XW-1:0] EXT_X    = XW'(EXT_W);
   localparam logic signed [XW-1:0] ZERO_X   = '0;
   localparam logic signed [VW-1:0] THRESH_V = VW'(THRESH);
   localparam logic signed [VW-1:0] RESET_V  = VW'(V_RESET);
   localparam logic [RW-1:0]        REFRAC_V = RW'(REFRAC);
   localparam logic [KW-1:0]        K_LAST   = KW'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FIRE} state_t;

   state_t               r_state;
   logic                 r_step_ready;
   logic                 r_spikes_valid;
   logic [N-1:0]         r_spikes;
   logic [N-1:0]         r_pre;
   logic [KW-1:0]        r_k;
   logic signed [VW-1:0] r_v   [N];
   logic [RW-1:0]        r_ref [N];
`ifdef LIF_SPIKE_COUNT_EN
   logic [7:0]           r_cnt [N];
`endif
   logic                 w_accept;

   function automatic logic signed [XW-1:0] sx(input logic signed [VW-1:0] a);
      return {{2{a[VW-1]}}, a};
   endfunction

   function automatic logic signed [XW-1:0] wx(input logic [15:0] a);
      return {{(XW-16){a[15]}}, a};
   endfunction

   function automatic logic signed [VW-1:0] sat(input logic signed [XW-1:0] a);
      if (a > V_MAX) return V_MAX[VW-1:0];
      if (a < V_MIN) return V_MIN[VW-1:0];
      return a[VW-1:0];
   endfunction

   assign w_accept = bus.step_valid && r_step_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= S_IDLE;
         r_step_ready   <= 1'b1;
         r_spikes_valid <= 1'b0;
         r_spikes       <= '0;
         r_pre          <= '0;
         r_k            <= '0;
         // NOTE: these arrays are neuron state, not RAM, so every entry takes the async reset.
         for (int j = 0; j < N; j++) begin
            r_v[j]   <= '0;
            r_ref[j] <= '0;
`ifdef LIF_SPIKE_COUNT_EN
            r_cnt[j] <= '0;
`endif
         end
      end else begin
         // NOTE: non-blocking throughout, so every neuron update reads the pre-edge state.
         r_spikes_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_pre        <= r_spikes;
                  r_k          <= '0;
                  r_step_ready <= 1'b0;
                  r_state      <= S_ACCUM;
                  // Leak never leaves the range; the single clamp covers the ext addition.
                  for (int j = 0; j < N; j++)
                     r_v[j] <= sat(sx(r_v[j]) - sx(r_v[j] >>> LEAK_SHIFT)
                                   + (bus.ext_spikes[j] ? EXT_X : ZERO_X));
               end
            end
            S_ACCUM: begin
               for (int j = 0; j < N; j++)
                  if (r_pre[r_k] && (KW'(j) != r_k))
                     r_v[j] <= sat(sx(r_v[j]) + wx(bus.weights_flat[(int'(r_k) * N + j) * 16 +: 16]));
               r_k <= r_k + KW'(1);
               if (r_k == K_LAST) r_state <= S_FIRE;
            end
            S_FIRE: begin
               for (int j = 0; j < N; j++) begin
                  if (r_ref[j] != '0) begin
                     r_ref[j]    <= r_ref[j] - RW'(1);
                     r_v[j]      <= RESET_V;
                     r_spikes[j] <= 1'b0;
                  end else if (r_v[j] >= THRESH_V) begin
                     r_spikes[j] <= 1'b1;
                     r_v[j]      <= RESET_V;
                     r_ref[j]    <= REFRAC_V;
`ifdef LIF_SPIKE_COUNT_EN
                     if (r_cnt[j] != 8'hFF) r_cnt[j] <= r_cnt[j] + 8'd1;
`endif
                  end else begin
                     r_spikes[j] <= 1'b0;
                  end
               end
               r_spikes_valid <= 1'b1;
               r_step_ready   <= 1'b1;
               r_state        <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
`ifdef LIF_SPIKE_COUNT_EN
         // Placed after the FSM so a clear overrides a same-cycle increment.
         if (bus.count_clear)
            for (int j = 0; j < N; j++) r_cnt[j] <= '0;
`endif
      end
   end

   assign bus.step_ready   = r_step_ready;
   assign bus.spikes       = r_spikes;
   assign bus.spikes_valid = r_spikes_valid;

   for (genvar j = 0; j < N; j++) begin : g_pack
      assign bus.membrane_flat[j*VW +: VW] = r_v[j];
`ifdef LIF_SPIKE_COUNT_EN
      assign bus.spike_count_flat[j*8 +: 8] = r_cnt[j];
`endif
   end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Randomized and directed bench for lif_neuron_array: instance A uses default parameters,
// instance B uses VW=16, EXT_W=4000, REFRAC=0; both are scored against an integer model.
module tb_lif_neuron_array;
   localparam int N      = 7;
   localparam int THRESH = 4000;
   localparam int LEAK   = 4;

   logic clk;
   logic rst_a_n, rst_b_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   mid_v0;

   lif_step_if #(.N(N), .VW(20)) ifa ();
   lif_step_if #(.N(N), .VW(16)) ifb ();

   lif_neuron_array #(.N(N)) u_dut_a (.clk(clk), .reset_n(rst_a_n), .bus(ifa));
   lif_neuron_array #(.N(N), .VW(16), .EXT_W(4000), .REFRAC(0))
      u_dut_b (.clk(clk), .reset_n(rst_b_n), .bus(ifb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain integer arithmetic, one call per timestep.
   int           p_vw  [2] = '{20, 16};
   int           p_ext [2] = '{1000, 4000};
   int           p_ref [2] = '{2, 0};
   int           m_v   [2][N];
   int           m_ref [2][N];
   int           m_cnt [2][N];
   int           m_w   [2][N][N];
   logic [N-1:0] m_spk [2];

   task automatic check(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int clampv(input int s, input int x);
      int hi, lo;
      hi = (1 << (p_vw[s] - 1)) - 1;
      lo = -(1 << (p_vw[s] - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   function automatic int floor_div(input int a, input int b);
      int q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   task automatic model_reset(input int s);
      m_spk[s] = '0;
      for (int j = 0; j < N; j++) begin
         m_v[s][j] = 0; m_ref[s][j] = 0; m_cnt[s][j] = 0;
      end
   endtask

   task automatic model_step(input int s, input logic [N-1:0] ext, input bit clr);
      logic [N-1:0] pre;
      pre = m_spk[s];
      for (int j = 0; j < N; j++) begin
         m_v[s][j] = clampv(s, m_v[s][j] - floor_div(m_v[s][j], 1 << LEAK));
         m_v[s][j] = clampv(s, m_v[s][j] + (ext[j] ? p_ext[s] : 0));
      end
      for (int k = 0; k < N; k++)
         if (pre[k])
            for (int j = 0; j < N; j++)
               if (j != k) m_v[s][j] = clampv(s, m_v[s][j] + m_w[s][k][j]);
      for (int j = 0; j < N; j++) begin
         if (m_ref[s][j] > 0) begin
            m_ref[s][j]--; m_v[s][j] = 0; m_spk[s][j] = 1'b0;
         end else if (m_v[s][j] >= THRESH) begin
            m_spk[s][j] = 1'b1; m_v[s][j] = 0; m_ref[s][j] = p_ref[s];
            if (m_cnt[s][j] < 255) m_cnt[s][j]++;
         end else begin
            m_spk[s][j] = 1'b0;
         end
         if (clr) m_cnt[s][j] = 0;
      end
   endtask

   task automatic set_w(input int s, input int i, input int j, input int val);
      m_w[s][i][j] = val;
      if (s == 0) ifa.weights_flat[(i*N + j)*16 +: 16] = 16'(val);
      else        ifb.weights_flat[(i*N + j)*16 +: 16] = 16'(val);
   endtask

   task automatic drive(input int s, input logic valid, input logic [N-1:0] ext);
      if (s == 0) begin ifa.step_valid = valid; ifa.ext_spikes = ext; end
      else        begin ifb.step_valid = valid; ifb.ext_spikes = ext; end
   endtask

   task automatic set_clear(input int s, input logic c);
`ifdef LIF_SPIKE_COUNT_EN
      if (s == 0) ifa.count_clear = c;
      else        ifb.count_clear = c;
`endif
   endtask

   function automatic logic dut_ready(input int s);
      return (s == 0) ? ifa.step_ready : ifb.step_ready;
   endfunction

   function automatic logic dut_valid(input int s);
      return (s == 0) ? ifa.spikes_valid : ifb.spikes_valid;
   endfunction

   function automatic logic [N-1:0] dut_spikes(input int s);
      return (s == 0) ? ifa.spikes : ifb.spikes;
   endfunction

   function automatic int dut_v(input int s, input int j);
      if (s == 0) return int'($signed(ifa.membrane_flat[j*20 +: 20]));
      return int'($signed(ifb.membrane_flat[j*16 +: 16]));
   endfunction

`ifdef LIF_SPIKE_COUNT_EN
   function automatic int dut_cnt(input int s, input int j);
      if (s == 0) return int'(ifa.spike_count_flat[j*8 +: 8]);
      return int'(ifb.spike_count_flat[j*8 +: 8]);
   endfunction
`endif

   task automatic do_reset(input int s);
      if (s == 0) rst_a_n = 1'b0; else rst_b_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      if (s == 0) rst_a_n = 1'b1; else rst_b_n = 1'b1;
      model_reset(s);
   endtask

   task automatic zero_weights(input int s);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) set_w(s, i, j, 0);
   endtask

   // One timestep: wait for ready, accept, then score latency, spikes, membranes, counters.
   task automatic run_step(input int s, input logic [N-1:0] ext, input bit clr_at_fire);
      int waitc, lat;
      waitc = 0;
      while (!dut_ready(s) && waitc < 50) begin @(posedge clk); #1; waitc++; end
      check("ready_before_step", dut_ready(s), 1);
      drive(s, 1'b1, ext);
      @(posedge clk); #1;
      drive(s, 1'b0, '0);
      model_step(s, ext, clr_at_fire);
      lat = 0;
      do begin
         @(posedge clk); #1; lat++;
         set_clear(s, 1'b0);
         if (lat == N) begin
            mid_v0 = dut_v(s, 0);
            if (clr_at_fire) set_clear(s, 1'b1);
         end
      end while (!dut_valid(s) && lat < 40);
      check("latency", lat, N + 1);
      check("ready_with_valid", dut_ready(s), 1);
      check("spikes", dut_spikes(s), m_spk[s]);
      for (int j = 0; j < N; j++) check("membrane", dut_v(s, j), m_v[s][j]);
`ifdef LIF_SPIKE_COUNT_EN
      for (int j = 0; j < N; j++) check("count", dut_cnt(s, j), m_cnt[s][j]);
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int           exp_v0 [5] = '{1000, 1938, 2817, 3641, 0};
      logic [N-1:0] exp_s  [5] = '{7'b0, 7'b0, 7'b0, 7'b0, 7'b0000001};
      int           nv, cyc, t [4];

      rst_a_n = 1'b0; rst_b_n = 1'b0;
      drive(0, 1'b0, '0); drive(1, 1'b0, '0);
      set_clear(0, 1'b0); set_clear(1, 1'b0);
      zero_weights(0); zero_weights(1);
      model_reset(0); model_reset(1);
      repeat (3) @(posedge clk);
      #1;
      rst_a_n = 1'b1; rst_b_n = 1'b1;

      // Reset values
      check("rst_spikes", ifa.spikes, 0);
      check("rst_valid", ifa.spikes_valid, 0);
      check("rst_ready", ifa.step_ready, 1);
      check("rst_membrane", (ifa.membrane_flat == '0), 1);
      check("rst_b_ready", ifb.step_ready, 1);
      check("rst_b_membrane", (ifb.membrane_flat == '0), 1);

      // External drive on neuron 0, five back-to-back steps
      for (int i = 0; i < 5; i++) begin
         run_step(0, 7'b0000001, 1'b0);
         check("ext_v0", dut_v(0, 0), exp_v0[i]);
         check("ext_spikes", dut_spikes(0), exp_s[i]);
      end

      // Recurrent excitation and refractory window
      set_w(0, 0, 1, 5000);
      run_step(0, 7'b0000000, 1'b0);
      check("rec_spikes", dut_spikes(0), 7'b0000010);
      check("rec_v1", dut_v(0, 1), 0);
      run_step(0, 7'b0000001, 1'b0);
      check("refrac_spike0", dut_spikes(0) & 7'b1, 0);
      check("refrac_v0", dut_v(0, 0), 0);
      run_step(0, 7'b0000001, 1'b0);
      check("refrac_over_v0", dut_v(0, 0), 1000);

      // Randomized steps, instance A (self-weights included, they must be ignored)
      for (int r = 0; r < 40; r++) begin
         if (r % 5 == 0)
            for (int i = 0; i < N; i++)
               for (int j = 0; j < N; j++)
                  set_w(0, i, j, int'($urandom_range(5000)) - 2500);
         run_step(0, N'($urandom), 1'b0);
      end

      // Handshake: a pulse during ACCUM is ignored
      do_reset(0);
      zero_weights(0);
      drive(0, 1'b1, '0);
      @(posedge clk); #1;
      drive(0, 1'b0, '0);
      repeat (3) begin @(posedge clk); #1; end
      drive(0, 1'b1, '0);
      @(posedge clk); #1;
      drive(0, 1'b0, '0);
      nv = 0;
      repeat (20) begin @(posedge clk); #1; if (ifa.spikes_valid) nv++; end
      check("pulse_ignored_valids", nv, 1);
      check("pulse_ready_after", ifa.step_ready, 1);

      // Handshake: step_valid held high gives one step every N+2 cycles
      drive(0, 1'b1, '0);
      nv = 0; cyc = 0;
      t = '{0, 0, 0, 0};
      while (nv < 4 && cyc < 60) begin
         @(posedge clk); #1; cyc++;
         if (ifa.spikes_valid) begin t[nv] = cyc; nv++; end
      end
      drive(0, 1'b0, '0);
      check("held_pulses", nv, 4);
      for (int i = 1; i < 4; i++) check("held_interval", t[i] - t[i-1], N + 2);
      repeat (3) begin @(posedge clk); #1; end
      check("held_idle_ready", ifa.step_ready, 1);

      // Abort: reset asserted while the step is at k=3
      run_step(0, 7'h7F, 1'b0);
      drive(0, 1'b1, '0);
      @(posedge clk); #1;
      drive(0, 1'b0, '0);
      repeat (3) begin @(posedge clk); #1; end
      check("abort_pre_membrane_nonzero", (ifa.membrane_flat != '0), 1);
      rst_a_n = 1'b0;
      #1;
      check("abort_ready", ifa.step_ready, 1);
      check("abort_valid", ifa.spikes_valid, 0);
      check("abort_spikes", ifa.spikes, 0);
      check("abort_membrane", (ifa.membrane_flat == '0), 1);
      repeat (2) @(posedge clk);
      #1;
      rst_a_n = 1'b1;
      model_reset(0);
      nv = 0;
      repeat (15) begin @(posedge clk); #1; if (ifa.spikes_valid) nv++; end
      check("abort_no_valid", nv, 0);
      run_step(0, 7'b0000001, 1'b0);

      // Saturation on instance B
      do_reset(1);
      zero_weights(1);
      run_step(1, 7'h7F, 1'b0);
      check("sat_step1_spikes", dut_spikes(1), 7'h7F);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) set_w(1, i, j, 32767);
      run_step(1, 7'h00, 1'b0);
      check("sat_pos_mid_v0", mid_v0, 32767);
      check("sat_pos_spikes", dut_spikes(1), 7'h7F);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) set_w(1, i, j, -32768);
      run_step(1, 7'h00, 1'b0);
      check("sat_neg_mid_v0", mid_v0, -32768);
      check("sat_neg_spikes", dut_spikes(1), 0);
      check("sat_neg_v6", dut_v(1, 6), -32768);

      // Randomized steps, instance B, full-range weights
      for (int r = 0; r < 30; r++) begin
         if (r % 3 == 0)
            for (int i = 0; i < N; i++)
               for (int j = 0; j < N; j++)
                  set_w(1, i, j, int'($urandom_range(65535)) - 32768);
         run_step(1, N'($urandom), 1'b0);
      end

`ifdef LIF_SPIKE_COUNT_EN
      // Counter saturation and clear priority
      do_reset(1);
      zero_weights(1);
      for (int r = 0; r < 300; r++) run_step(1, 7'b0000100, 1'b0);
      check("cnt_saturated", dut_cnt(1, 2), 255);
      run_step(1, 7'b0000100, 1'b1);
      check("cnt_clear_over_fire", dut_cnt(1, 2), 0);
      run_step(1, 7'b0000100, 1'b0);
      check("cnt_after_clear", dut_cnt(1, 2), 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
